instr_assembler: RTL and testbench

//   Field-to-word encoder for the Hack CPU: the write-side counterpart of the instruction decoder.

---
 rtl/hack_pkg.sv | 45 ++++
 rtl/instr_skid_fifo.sv | 66 ++++++
 rtl/instr_assembler.sv | 132 +++++++++++++
 tb/tb_instr_assembler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: shared types and helpers for the Hack instruction assembler.
//   instr_t       16-bit Hack instruction word
//   asm_state_e   assembler load FSM states
//   encode_instr  packs decoded fields into a Hack word
package hack_pkg;

   localparam int INSTR_W = 16;
   localparam int VALUE_W = 15;
   localparam int COMP_W  = 6;
   localparam int DEST_W  = 3;
   localparam int JUMP_W  = 3;

   typedef logic [INSTR_W-1:0] instr_t;

   localparam logic       A_INSTR  = 1'b0;
   localparam logic       C_INSTR  = 1'b1;
   localparam logic [2:0] C_PREFIX = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } asm_state_e;

   // A-instruction: MSB 0 followed by the 15-bit constant.
   // C-instruction: the two spare bits after the opcode are driven 1.
   function automatic instr_t encode_instr(
      input logic               typ,
      input logic [VALUE_W-1:0] value,
      input logic               a,
      input logic [COMP_W-1:0]  c,
      input logic [DEST_W-1:0]  d,
      input logic [JUMP_W-1:0]  j
   );
      instr_t w;
      if (typ == A_INSTR) begin
         w = {1'b0, value};
      end else begin
         w = {C_PREFIX, a, c, d, j};
      end
      return w;
   endfunction

endpackage

// File: rtl/instr_skid_fifo.sv
// instr_skid_fifo: 2-entry synchronous FIFO with valid/ready on both sides.
//   clk, rst                  clock and synchronous active-high reset
//   in_valid/in_ready/in_data write side; accepted when in_valid & in_ready
//   out_valid/out_ready/out_data read side; head popped when both high
//   count                     number of stored entries (0..2)
// in_ready depends only on the stored count, so a full FIFO never accepts
// a push even when a pop happens in the same cycle.
module instr_skid_fifo #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [1:0]    count
);

   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic       push;
   logic       pop;

   assign in_ready  = (count_reg != 2'd2);
   assign out_valid = (count_reg != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [DW-1:0] entry_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               entry_reg <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
               entry_reg <= in_data;
            end
         end
      end
   endgenerate

   assign out_data = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/instr_assembler.sv
// instr_assembler: packs decoded Hack instruction fields into 16-bit words
// and emits them with sequential ROM addresses for the instruction ROM writer.
//   clk, rst        clock and synchronous active-high reset
//   start           pulse: begin a program load at address 0 (IDLE/DONE only)
//   in_valid/in_ready, in_type/in_value/in_a/in_c/in_d/in_j/in_last
//                   decoded field set handshake
//   out_valid/out_ready, out_instr/out_addr
//                   encoded word handshake toward the ROM writer
//   done            level: program fully emitted, held until start or rst
//   err_overflow    sticky: capacity filled without in_last
//   instr_cnt       words emitted since start
module instr_assembler
   import hack_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_type,
   input  logic [DW-2:0] in_value,
   input  logic          in_a,
   input  logic [5:0]    in_c,
   input  logic [2:0]    in_d,
   input  logic [2:0]    in_j,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_instr,
   output logic [AW-1:0] out_addr,
   output logic          done,
   output logic          err_overflow,
   output logic [AW:0]   instr_cnt
);

   // Accept count value just before the final slot of a full-capacity load.
   localparam logic [AW:0] LAST_SLOT = {1'b0, {AW{1'b1}}};

   asm_state_e    state_reg;
   logic [AW-1:0] addr_reg;
   logic [AW:0]   cnt_reg;
   logic [AW:0]   acc_reg;
   logic          done_reg;
   logic          ovf_reg;

   logic          fifo_in_ready;
   logic          fifo_out_valid;
   logic [1:0]    fifo_count;
   logic [DW-1:0] word;
   logic          accept;
   logic          pop;

   assign in_ready = (state_reg == LOAD) && fifo_in_ready;
   assign accept   = in_valid && in_ready;
   assign pop      = fifo_out_valid && out_ready;
   assign word     = encode_instr(in_type, in_value, in_a, in_c, in_d, in_j);

   instr_skid_fifo #(
      .DW (DW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_ready  (fifo_in_ready),
      .in_data   (word),
      .out_valid (fifo_out_valid),
      .out_ready (out_ready),
      .out_data  (out_instr),
      .count     (fifo_count)
   );

   assign out_valid    = fifo_out_valid;
   assign out_addr     = addr_reg;
   assign instr_cnt    = cnt_reg;
   assign done         = done_reg;
   assign err_overflow = ovf_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         cnt_reg   <= '0;
         acc_reg   <= '0;
         done_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         // Pops can happen in LOAD and DRAIN. The address holds at its top
         // value after the last word of a full-capacity load instead of
         // wrapping back to 0.
         if (pop) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (addr_reg != {AW{1'b1}}) addr_reg <= addr_reg + 1'b1;
         end

         case (state_reg)
            IDLE, DONE: begin
               // FIFO is empty here, so clearing the counters cannot race a pop.
               if (start) begin
                  state_reg <= LOAD;
                  addr_reg  <= '0;
                  cnt_reg   <= '0;
                  acc_reg   <= '0;
                  done_reg  <= 1'b0;
                  ovf_reg   <= 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  acc_reg <= acc_reg + 1'b1;
                  if (in_last) begin
                     state_reg <= DRAIN;
                  end else if (acc_reg == LAST_SLOT) begin
                     ovf_reg   <= 1'b1;
                     state_reg <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (fifo_count == 2'd0) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler (built with AW=2 so capacity is reachable).
module tb_instr_assembler;

   localparam int DW = 16;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_type = 1'b0;
   logic [DW-2:0] in_value = '0;
   logic          in_a = 1'b0;
   logic [5:0]    in_c = '0;
   logic [2:0]    in_d = '0;
   logic [2:0]    in_j = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_instr;
   logic [AW-1:0] out_addr;
   logic          done;
   logic          err_overflow;
   logic [AW:0]   instr_cnt;

   instr_assembler #(.DW(DW), .AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_type      (in_type),
      .in_value     (in_value),
      .in_a         (in_a),
      .in_c         (in_c),
      .in_d         (in_d),
      .in_j         (in_j),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_addr     (out_addr),
      .done         (done),
      .err_overflow (err_overflow),
      .instr_cnt    (instr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] instr;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [AW-1:0] exp_addr = '0;
   int            n_checks = 0;
   int            n_pass = 0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] held_instr = '0;
   logic [AW-1:0] held_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
   endtask

   // Monitor: samples on the falling edge; a word with out_valid & out_ready
   // here is consumed at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && out_valid) begin
            chk("stall_instr_hold", out_instr, held_instr);
            chk("stall_addr_hold", out_addr, held_addr);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got %h at addr %0d, expected none", out_instr, out_addr);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_instr", out_instr, mon_e.instr);
               chk("out_addr", out_addr, mon_e.addr);
               $display("pop  instr=%h addr=%0d", out_instr, out_addr);
            end
         end
         stall_prev = out_valid && !out_ready;
         held_instr = out_instr;
         held_addr  = out_addr;
      end
   end

   // Offers one field set for up to 'budget' cycles; on acceptance the
   // hand-computed word is queued with the next expected address.
   task automatic send(input logic typ, input logic [14:0] val, input logic a,
                       input logic [5:0] c, input logic [2:0] d, input logic [2:0] j,
                       input logic last, input logic [15:0] exp_word,
                       input int budget, output bit got);
      in_type = typ; in_value = val; in_a = a; in_c = c; in_d = d; in_j = j;
      in_last = last; in_valid = 1'b1;
      got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         if (in_ready) begin
            exp_q.push_back('{exp_word, exp_addr});
            exp_addr = exp_addr + 1'b1;
            got = 1'b1;
            $display("push instr=%h last=%0b", exp_word, last);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_ok(input logic typ, input logic [14:0] val, input logic a,
                          input logic [5:0] c, input logic [2:0] d, input logic [2:0] j,
                          input logic last, input logic [15:0] exp_word);
      bit got;
      send(typ, val, a, c, d, j, last, exp_word, 20, got);
      chk("accept", got, 1);
   endtask

   task automatic start_load();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_addr = '0;
      chk("start_done_clr", done, 0);
      chk("start_ovf_clr", err_overflow, 0);
      chk("start_cnt_clr", instr_cnt, 0);
      chk("start_in_ready", in_ready, 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done", done, 1);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", err_overflow, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_instr_cnt", instr_cnt, 0);

      // Program of 4 words; A fields a/c/d/j and C value must be ignored.
      out_ready = 1'b1;
      start_load();
      send_ok(1'b0, 15'h7FFF, 1'b1, 6'h3F, 3'h7, 3'h7, 1'b0, 16'h7FFF);
      chk("latency_valid", out_valid, 1);
      chk("latency_instr", out_instr, 16'h7FFF);
      chk("latency_addr", out_addr, 0);
      send_ok(1'b1, 15'h1234, 1'b0, 6'b111111, 3'b010, 3'b000, 1'b0, 16'hEFD0);
      send_ok(1'b1, 15'h0000, 1'b0, 6'b000010, 3'b010, 3'b000, 1'b0, 16'hE090);
      send_ok(1'b1, 15'h7FFF, 1'b0, 6'b110111, 3'b001, 3'b000, 1'b1, 16'hEDC8);
      wait_done();
      chk("prog1_cnt", instr_cnt, 4);
      chk("prog1_ovf", err_overflow, 0);
      chk("prog1_in_ready", in_ready, 0);

      // Back-pressure: two accepts fill the FIFO, third is refused until release.
      out_ready = 1'b0;
      start_load();
      send_ok(1'b0, 15'h0001, 1'b0, 6'h0, 3'h0, 3'h0, 1'b0, 16'h0001);
      send_ok(1'b0, 15'h0002, 1'b0, 6'h0, 3'h0, 3'h0, 1'b0, 16'h0002);
      chk("full_in_ready", in_ready, 0);
      send(1'b0, 15'h0003, 1'b0, 6'h0, 3'h0, 3'h0, 1'b1, 16'h0003, 3, got);
      chk("full_blocked", got, 0);
      out_ready = 1'b1;
      send_ok(1'b0, 15'h0003, 1'b0, 6'h0, 3'h0, 3'h0, 1'b1, 16'h0003);
      wait_done();
      chk("stall_cnt", instr_cnt, 3);

      // Capacity 4 with no in_last: 5th word must be refused.
      start_load();
      send_ok(1'b0, 15'h000A, 1'b0, 6'h0, 3'h0, 3'h0, 1'b0, 16'h000A);
      send_ok(1'b0, 15'h000B, 1'b0, 6'h0, 3'h0, 3'h0, 1'b0, 16'h000B);
      send_ok(1'b0, 15'h000C, 1'b0, 6'h0, 3'h0, 3'h0, 1'b0, 16'h000C);
      chk("ovf_before_cap", err_overflow, 0);
      send_ok(1'b0, 15'h000D, 1'b0, 6'h0, 3'h0, 3'h0, 1'b0, 16'h000D);
      chk("ovf_set", err_overflow, 1);
      chk("ovf_in_ready", in_ready, 0);
      send(1'b0, 15'h000E, 1'b0, 6'h0, 3'h0, 3'h0, 1'b0, 16'h000E, 4, got);
      chk("ovf_5th_refused", got, 0);
      wait_done();
      chk("ovf_cnt", instr_cnt, 4);
      chk("ovf_sticky", err_overflow, 1);

      // Restart after DONE clears flags; first word goes to address 0.
      start_load();
      send_ok(1'b1, 15'h0000, 1'b1, 6'b110000, 3'b000, 3'b111, 1'b1, 16'hFC07);
      wait_done();
      chk("restart_cnt", instr_cnt, 1);

      // Reset mid-load with two words buffered discards them.
      out_ready = 1'b0;
      start_load();
      send_ok(1'b0, 15'h0055, 1'b0, 6'h0, 3'h0, 3'h0, 1'b0, 16'h0055);
      send_ok(1'b0, 15'h0066, 1'b0, 6'h0, 3'h0, 3'h0, 1'b0, 16'h0066);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_cnt", instr_cnt, 0);
      chk("midrst_done", done, 0);
      chk("midrst_instr", out_instr, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("idle_in_ready", in_ready, 0);
      chk("idle_out_valid", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
